// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encoding and default width for the countdown timer
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with terminal-count pulse, pause, abort and auto-reload
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] out_count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload_val, reload_val_n;
  logic             reload_en, reload_en_n;

  assign load_ready = (state == IDLE);

  // Next-state, next-count and reload-latch decisions; abort outranks decrement and reload
  always_comb begin
    state_n      = state;
    count_n      = out_count;
    reload_val_n = reload_val;
    reload_en_n  = reload_en;
    case (state)
      IDLE: begin
        if (load_valid) begin
          reload_val_n = load_value;
          reload_en_n  = auto_reload;
          if (load_value == '0) begin
            state_n = DONE;
            count_n = '0;
          end else begin
            state_n = RUN;
            count_n = load_value;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          count_n = '0;
        end else if (en) begin
          // count of 1 (or a defensive 0) terminates without ever going below zero
          if (out_count <= ONE) begin
            state_n = DONE;
            count_n = '0;
          end else begin
            count_n = out_count - ONE;
          end
        end
      end
      DONE: begin
        if (!abort && reload_en && (reload_val != '0)) begin
          state_n = RUN;
          count_n = reload_val;
        end else begin
          state_n = IDLE;
          count_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  // State, count, reload latches and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out_count  <= '0;
      reload_val <= '0;
      reload_en  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      out_count  <= count_n;
      reload_val <= reload_val_n;
      reload_en  <= reload_en_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] out_count;
  logic             busy;
  logic             done;

  int vectors;
  int miscompares;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .en          (en),
    .abort       (abort),
    .out_count   (out_count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input int cnt, input logic b, input logic d, input logic r);
    check({tag, ".count"}, 32'(out_count), 32'(cnt));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".ready"}, 32'(load_ready), 32'(r));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    load_valid  = 1'b0;
    load_value  = '0;
    auto_reload = 1'b0;
    en          = 1'b1;
    abort       = 1'b0;

    step();
    step();
    check_state("reset", 0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;

    // load 5, no reload: 5,4,3,2,1 then DONE on the 6th edge
    load_valid = 1'b1;
    load_value = 5'd5;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_state("run5", 5 - i, 1'b1, 1'b0, 1'b0);
      step();
    end
    check_state("done5", 0, 1'b1, 1'b1, 1'b0);
    step();
    check_state("idle5", 0, 1'b0, 1'b0, 1'b1);

    // load 3 with auto-reload: done every 4 cycles, then abort
    load_valid  = 1'b1;
    load_value  = 5'd3;
    auto_reload = 1'b1;
    step();
    load_valid  = 1'b0;
    auto_reload = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        check_state("ar3", 3 - i, 1'b1, 1'b0, 1'b0);
        step();
      end
      check_state("ar3_done", 0, 1'b1, 1'b1, 1'b0);
      step();
    end
    check_state("ar3_reload", 3, 1'b1, 1'b0, 1'b0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_state("ar3_abort", 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("ar3_nodone", 32'(done), 32'd0);
    end

    // load 4, pause 3 cycles at count 2: done on edge 8 instead of 5
    load_valid = 1'b1;
    load_value = 5'd4;
    step();
    load_valid = 1'b0;
    check_state("p4_a", 4, 1'b1, 1'b0, 1'b0);
    step();
    check_state("p4_b", 3, 1'b1, 1'b0, 1'b0);
    step();
    check_state("p4_c", 2, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("p4_hold", 2, 1'b1, 1'b0, 1'b0);
    end
    en = 1'b1;
    step();
    check_state("p4_d", 1, 1'b1, 1'b0, 1'b0);
    step();
    check_state("p4_done", 0, 1'b1, 1'b1, 1'b0);
    step();
    check_state("p4_idle", 0, 1'b0, 1'b0, 1'b1);

    // load 0 with auto-reload and a simultaneous idle abort: DONE then IDLE
    load_valid  = 1'b1;
    load_value  = 5'd0;
    auto_reload = 1'b1;
    abort       = 1'b1;
    step();
    load_valid  = 1'b0;
    auto_reload = 1'b0;
    abort       = 1'b0;
    check_state("z_done", 0, 1'b1, 1'b1, 1'b0);
    step();
    check_state("z_idle", 0, 1'b0, 1'b0, 1'b1);

    // load 20, stray load during RUN, then reset at count 7
    load_valid = 1'b1;
    load_value = 5'd20;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_state("r20_a", 15, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b1;
    load_value = 5'd9;
    step();
    load_valid = 1'b0;
    check_state("r20_ignore", 14, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    check_state("r20_b", 7, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check_state("r20_rst", 0, 1'b0, 1'b0, 1'b1);
    step();
    check_state("r20_rst_hold", 0, 1'b0, 1'b0, 1'b1);

    // release reset and accept on the very first edge: load 31, no wrap
    rst        = 1'b1;
    load_valid = 1'b1;
    load_value = 5'd31;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 31; i++) begin
      check("m31_count", 32'(out_count), 32'(31 - i));
      check("m31_nodone", 32'(done), 32'd0);
      step();
    end
    check_state("m31_done", 0, 1'b1, 1'b1, 1'b0);
    step();
    check_state("m31_idle", 0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
